td4_seq_ctrl: RTL and testbench
===============================

Name: td4_seq_ctrl

Overview:
- Fetch/execute sequencer for the TD4 4-bit CPU.
- Drives the program ROM address, latches the 8-bit instruction word returned by the ROM, and executes it.
- Owns the program counter, registers A and B, the carry flag and the output port.
- Two-phase machine: FETCH then EXEC, so one instruction takes 2 clocks; a run input gates progress for single-stepping.

Parameters:
RESET_PC, 4'h0, program counter value loaded on reset
OUT_RESET, 4'h0, out_port value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  clock enable for the sequencer; 0 freezes all state
adr  output  4  ROM address, equals PC register
dout  input  8  ROM data; [7:4] opcode, [3:0] immediate Im
in_port  input  4  input port, already synchronised by the caller
out_port  output  4  registered output port
carry  output  1  registered carry flag
exec_phase  output  1  0 = FETCH, 1 = EXEC

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (async, immediate):
  - pc=RESET_PC, A=0, B=0, IR=8'h00, carry=0, out_port=OUT_RESET, state=FETCH.
  - Reset mid-EXEC aborts the instruction with no partial register write.
- adr = pc, combinational from the register. ROM is combinational, so dout is valid in the same cycle.
- FETCH, run=1: IR<=dout, state->EXEC. No other state changes.
- EXEC, run=1: execute IR, update pc/A/B/carry/out_port, state->FETCH.
- Any state, run=0: hold everything, including IR and pc.
- Opcodes, with Im = IR[3:0]; default next pc is pc+1:
  - 0000 ADD A,Im: {carry,A} <= A+Im (5-bit result).
  - 0101 ADD B,Im: {carry,B} <= B+Im (5-bit result).
  - 0011 MOV A,Im: A<=Im.
  - 0111 MOV B,Im: B<=Im.
  - 0001 MOV A,B: A<=B.
  - 0100 MOV B,A: B<=A.
  - 0010 IN A: A<=in_port.
  - 0110 IN B: B<=in_port.
  - 1001 OUT B: out_port<=B.
  - 1011 OUT Im: out_port<=Im.
  - 1111 JMP Im: pc<=Im.
  - 1110 JNC Im: pc<=Im if carry==0, else pc+1. The test uses the carry value before this instruction.
  - 1000, 1010, 1100, 1101: NOP.
- Carry rule: every non-ADD instruction, including JMP, JNC and NOP, clears carry in EXEC.
- Width and wrap rules:
  - All arithmetic is 4-bit.
  - pc increments mod 16 (15 -> 0).
  - ADD of 15+1 gives register 0, carry 1.
- in_port is sampled on the EXEC clock edge only.

Optional Feature:
- Macro TD4_HALT_DETECT_EN.
- Defined:
  - Adds output port halted (1 bit, reset 0).
  - In EXEC, a JMP with Im==pc, or a taken JNC with Im==pc, sets halted=1.
  - halted is sticky until reset. While halted=1 the sequencer ignores run and freezes all state.
- Undefined: the halted port is absent; self-jumps loop forever at 2 clocks per iteration.

Test Plan:
- Reset check: reset asserted with clk stopped -> adr=0, out_port=0, carry=0, exec_phase=0, all immediately.
- Add with carry: ROM 0:8'h33, 1:8'h0E, 2:8'h40, 3:8'h90, run=1.
  - After clock 4: carry=1.
  - After clock 6: carry=0.
  - After clock 8: out_port=4'h1, adr=4.
- JNC both ways: carry=1 then JNC 8'hE5 -> next adr=pc+1, carry=0; repeated JNC 8'hE5 -> adr=5.
- Input path: in_port=4'hA; ROM 8'h20, 8'h40, 8'h90 -> out_port=4'hA after 6 clocks.
- Wrap and run gating:
  - ROM filled with NOP 8'h80 -> adr goes 15 -> 0.
  - run=0 held 3 clocks in EXEC -> adr, IR and exec_phase unchanged.
- Halt detect (TD4_HALT_DETECT_EN): ROM 3:8'hF3 -> halted=1 two clocks after adr=3 is fetched; adr stays 3 with run=1.

Source files
------------

// File: rtl/td4_seq_ctrl.sv
// td4_seq_ctrl: fetch/execute sequencer for the TD4 4-bit CPU.
// Owns pc, registers A/B, the instruction register, carry and the output port.
// Every instruction takes two clocks: FETCH latches the ROM word, EXEC runs it.
// run gates the whole sequencer so it can be single-stepped.
// Optional feature macro: TD4_HALT_DETECT_EN adds a sticky 'halted' output.
// It is set by a self-jump (JMP to own pc, or a taken JNC to own pc), and it
// freezes the sequencer until reset.
//
// Handshake: there is no valid/ready pair. The ROM is combinational: adr is
// driven from pc and dout is expected to be valid in the same cycle. run acts
// as a plain clock enable, so when run=0 every register holds its value.
module td4_seq_ctrl #(
  parameter logic [3:0] RESET_PC  = 4'h0,
  parameter logic [3:0] OUT_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [3:0] adr,
  input  logic [7:0] dout,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry,
`ifdef TD4_HALT_DETECT_EN
  output logic       halted,
`endif
  output logic       exec_phase
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] pc;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [7:0] ir;

  logic [3:0] op;
  logic [3:0] im;
  logic [4:0] sum_a;
  logic [4:0] sum_b;

  logic [3:0] nxt_pc;
  logic [3:0] nxt_a;
  logic [3:0] nxt_b;
  logic [3:0] nxt_out;
  logic       nxt_carry;
  logic       step;

  assign op         = ir[7:4];
  assign im         = ir[3:0];
  assign sum_a      = {1'b0, reg_a} + {1'b0, im};
  assign sum_b      = {1'b0, reg_b} + {1'b0, im};
  assign adr        = pc;
  assign exec_phase = (state == EXEC);

`ifdef TD4_HALT_DETECT_EN
  logic halt_hit;
  // A jump that lands back on its own address can never make progress.
  assign halt_hit = ((op == 4'b1111) || ((op == 4'b1110) && !carry)) && (im == pc);
  assign step     = run && !halted;
`else
  assign step     = run;
`endif

  // Decode the latched instruction into the register values EXEC will commit.
  // Carry defaults to 0 so every non-ADD instruction clears it.
  always_comb begin
    nxt_pc    = pc + 4'd1;
    nxt_a     = reg_a;
    nxt_b     = reg_b;
    nxt_out   = out_port;
    nxt_carry = 1'b0;
    case (op)
      4'b0000: {nxt_carry, nxt_a} = sum_a;
      4'b0101: {nxt_carry, nxt_b} = sum_b;
      4'b0011: nxt_a = im;
      4'b0111: nxt_b = im;
      4'b0001: nxt_a = reg_b;
      4'b0100: nxt_b = reg_a;
      4'b0010: nxt_a = in_port;
      4'b0110: nxt_b = in_port;
      4'b1001: nxt_out = reg_b;
      4'b1011: nxt_out = im;
      4'b1111: nxt_pc = im;
      4'b1110: if (!carry) nxt_pc = im;
      default: ;
    endcase
  end

  // Two-phase sequencer: FETCH latches IR, EXEC commits the decoded results.
  // Reset in the middle of EXEC discards the instruction entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      reg_a    <= 4'h0;
      reg_b    <= 4'h0;
      ir       <= 8'h00;
      carry    <= 1'b0;
      out_port <= OUT_RESET;
`ifdef TD4_HALT_DETECT_EN
      halted   <= 1'b0;
`endif
    end else if (step) begin
      case (state)
        FETCH: begin
          ir    <= dout;
          state <= EXEC;
        end
        EXEC: begin
          pc       <= nxt_pc;
          reg_a    <= nxt_a;
          reg_b    <= nxt_b;
          carry    <= nxt_carry;
          out_port <= nxt_out;
          state    <= FETCH;
`ifdef TD4_HALT_DETECT_EN
          if (halt_hit) halted <= 1'b1;
`endif
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_seq_ctrl.sv
// tb_td4_seq_ctrl: directed bench for td4_seq_ctrl.
// A table of small programs, each run for 16 clocks from reset, with the
// expected out_port/carry/adr worked out by hand; then hand-written sequences
// for async reset, run gating, step-wise ADD/JNC timing and the self-jump case.
module tb_td4_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       clk_en;
  logic       reset;
  logic       run;
  logic [3:0] adr;
  logic [7:0] dout;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       carry;
  logic       exec_phase;
`ifdef TD4_HALT_DETECT_EN
  logic       halted;
`endif

  logic [7:0] rom [16];

  int n_cmp;
  int n_err;

  // ROM is combinational, as the sequencer expects.
  assign dout = rom[adr];

  td4_seq_ctrl #(
    .RESET_PC (4'h0),
    .OUT_RESET(4'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .adr       (adr),
    .dout      (dout),
    .in_port   (in_port),
    .out_port  (out_port),
    .carry     (carry),
`ifdef TD4_HALT_DETECT_EN
    .halted    (halted),
`endif
    .exec_phase(exec_phase)
  );

  // Gated clock so reset can be checked with the clock stopped.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_prog(input logic [63:0] prog);
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    for (int i = 0; i < 8; i++) rom[i] = prog[63 - 8*i -: 8];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] prog;
    logic [3:0]  in_val;
    logic [3:0]  exp_out;
    logic        exp_carry;
    logic [3:0]  exp_adr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clk_en  = 1'b0;
    reset   = 1'b0;
    run     = 1'b0;
    in_port = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;

    // program (8 bytes from address 0, rest NOP), in_port, out, carry, adr after 16 clocks
    vecs[0]  = '{64'h33_0E_40_90_80_80_80_80, 4'h0, 4'h1, 1'b0, 4'h8};
    vecs[1]  = '{64'h7F_58_90_80_80_80_80_5F, 4'h0, 4'h7, 1'b1, 4'h8};
    vecs[2]  = '{64'h20_40_90_80_80_80_80_80, 4'hA, 4'hA, 1'b0, 4'h8};
    vecs[3]  = '{64'h60_10_0C_40_90_80_80_80, 4'h5, 4'h1, 1'b0, 4'h8};
    vecs[4]  = '{64'hF6_B1_B2_B3_B4_B5_B9_80, 4'h0, 4'h9, 1'b0, 4'hD};
    vecs[5]  = '{64'h3F_E4_B1_B2_B7_80_80_80, 4'h0, 4'h7, 1'b0, 4'hA};
    vecs[6]  = '{64'h3F_01_E5_E6_B1_BB_BC_80, 4'h0, 4'hC, 1'b0, 4'hA};
    vecs[7]  = '{64'h3F_01_C0_B4_3F_0F_0F_D0, 4'h0, 4'h4, 1'b0, 4'h8};
    vecs[8]  = '{64'h3A_40_5B_90_80_80_80_80, 4'h0, 4'h5, 1'b0, 4'h8};
    vecs[9]  = '{64'hF9_80_80_80_80_80_80_80, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[10] = '{64'h20_40_5E_90_80_80_80_01, 4'hF, 4'hD, 1'b1, 4'h8};

    // ---- reset with clock stopped ----
    #2 reset = 1'b1;
    #2;
    check("rst_adr",   8'(adr),        8'h0);
    check("rst_out",   8'(out_port),   8'h0);
    check("rst_carry", 8'(carry),      8'h0);
    check("rst_phase", 8'(exec_phase), 8'h0);
`ifdef TD4_HALT_DETECT_EN
    check("rst_halted", 8'(halted), 8'h0);
`endif
    reset  = 1'b0;
    clk_en = 1'b1;

    // ---- table-driven programs ----
    for (int v = 0; v < 11; v++) begin
      load_prog(vecs[v].prog);
      in_port = vecs[v].in_val;
      run     = 1'b1;
      do_reset();
      tick(16);
      check($sformatf("vec%0d_out", v),   8'(out_port),   8'(vecs[v].exp_out));
      check($sformatf("vec%0d_carry", v), 8'(carry),      8'(vecs[v].exp_carry));
      check($sformatf("vec%0d_adr", v),   8'(adr),        8'(vecs[v].exp_adr));
      check($sformatf("vec%0d_phase", v), 8'(exec_phase), 8'h0);
    end

    // ---- ADD with carry, step-wise ----
    load_prog(64'h33_0E_40_90_80_80_80_80);
    in_port = 4'h0;
    do_reset();
    tick(4);
    check("addc_c4", 8'(carry), 8'h1);
    tick(2);
    check("addc_c6", 8'(carry), 8'h0);
    tick(2);
    check("addc_out8", 8'(out_port), 8'h1);
    check("addc_adr8", 8'(adr),      8'h4);

    // ---- JNC not taken then taken ----
    load_prog(64'h3F_01_E5_E5_80_80_80_80);
    do_reset();
    tick(4);
    check("jnc_c_set", 8'(carry), 8'h1);
    check("jnc_adr2",  8'(adr),   8'h2);
    tick(2);
    check("jnc_nt_adr",   8'(adr),   8'h3);
    check("jnc_nt_carry", 8'(carry), 8'h0);
    tick(2);
    check("jnc_tk_adr", 8'(adr), 8'h5);

    // ---- wrap 15 -> 0 with all NOPs ----
    load_prog(64'h80_80_80_80_80_80_80_80);
    do_reset();
    tick(30);
    check("wrap_adr15", 8'(adr), 8'hF);
    tick(2);
    check("wrap_adr0", 8'(adr), 8'h0);

    // ---- run gating in EXEC and FETCH ----
    load_prog(64'hB9_80_80_80_80_80_80_80);
    do_reset();
    tick(1);
    check("gate_phase_exec", 8'(exec_phase), 8'h1);
    run    = 1'b0;
    rom[0] = 8'hBA;  // a changed ROM word must not reach IR while held in EXEC
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("gate_e%0d_adr", i),   8'(adr),        8'h0);
      check($sformatf("gate_e%0d_phase", i), 8'(exec_phase), 8'h1);
      check($sformatf("gate_e%0d_out", i),   8'(out_port),   8'h0);
    end
    run = 1'b1;
    tick(1);
    check("gate_ir_held_out", 8'(out_port),   8'h9);
    check("gate_adr1",        8'(adr),        8'h1);
    check("gate_phase_fetch", 8'(exec_phase), 8'h0);
    run = 1'b0;
    tick(3);
    check("gate_f_adr",   8'(adr),        8'h1);
    check("gate_f_phase", 8'(exec_phase), 8'h0);
    run = 1'b1;

    // ---- async reset mid-EXEC with clock stopped ----
    load_prog(64'hB5_B6_80_80_80_80_80_80);
    do_reset();
    tick(3);
    check("mid_pre_out",   8'(out_port),   8'h5);
    check("mid_pre_phase", 8'(exec_phase), 8'h1);
    clk_en = 1'b0;
    #3 reset = 1'b1;
    #2;
    check("mid_rst_out",   8'(out_port),   8'h0);
    check("mid_rst_adr",   8'(adr),        8'h0);
    check("mid_rst_phase", 8'(exec_phase), 8'h0);
    reset  = 1'b0;
    clk_en = 1'b1;
    tick(1);
    check("mid_post_out", 8'(out_port), 8'h0);

    // ---- self-jump at address 3 ----
    load_prog(64'h80_80_80_F3_80_80_80_80);
    do_reset();
    tick(7);
    check("self_fetch_adr",   8'(adr),        8'h3);
    check("self_fetch_phase", 8'(exec_phase), 8'h1);
`ifdef TD4_HALT_DETECT_EN
    check("self_pre_halted", 8'(halted), 8'h0);
`endif
    tick(1);
    check("self_exec_adr", 8'(adr), 8'h3);
`ifdef TD4_HALT_DETECT_EN
    check("self_halted", 8'(halted), 8'h1);
`endif
    tick(6);
    check("self_hold_adr",   8'(adr),        8'h3);
    check("self_hold_phase", 8'(exec_phase), 8'h0);
    check("self_hold_carry", 8'(carry),      8'h0);
`ifdef TD4_HALT_DETECT_EN
    check("self_hold_halted", 8'(halted), 8'h1);
    tick(1);
    check("self_frozen_phase", 8'(exec_phase), 8'h0);
`endif

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
